// File: rtl/data_mem_stage_if.sv
// EX/MEM -> MEM/WB bundle for the MEM stage of the five-stage MIPS pipeline.
// The master side is whoever drives the EX/MEM register outputs and consumes
// the MEM/WB results; the slave side is the data_mem_stage itself.
interface data_mem_stage_if;
  logic        RegWrite;
  logic        MemToReg;
  logic [1:0]  MemWrite;
  logic [1:0]  MemRead;
  logic [31:0] RData2;
  logic [31:0] ALUResult;
  logic [31:0] PCAddResult;
  logic [4:0]  RdReg;

  logic        RegWriteOut;
  logic        MemToRegOut;
  logic [31:0] ReadDataOut;
  logic [31:0] ALUResultOut;
  logic [31:0] PCAddResultOut;
  logic [4:0]  RdRegOut;
  logic        MisalignOut;
  logic [31:0] WbData;

  modport master (
    output RegWrite, MemToReg, MemWrite, MemRead, RData2, ALUResult,
           PCAddResult, RdReg,
    input  RegWriteOut, MemToRegOut, ReadDataOut, ALUResultOut,
           PCAddResultOut, RdRegOut, MisalignOut, WbData
  );

  modport slave (
    input  RegWrite, MemToReg, MemWrite, MemRead, RData2, ALUResult,
           PCAddResult, RdReg,
    output RegWriteOut, MemToRegOut, ReadDataOut, ALUResultOut,
           PCAddResultOut, RdRegOut, MisalignOut, WbData
  );
endinterface

// File: rtl/data_mem_stage.sv
// MEM stage: little-endian word/half/byte loads and stores against a word
// array, followed by the MEM/WB pipeline register and write-back mux.
module data_mem_stage #(
  parameter int DEPTH_WORDS = 1024
) (
  input logic            Clk,
  input logic            Reset,
  data_mem_stage_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [1:0]    byte_sel;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [31:0]   load_data;
  logic [31:0]   store_data;
  logic [3:0]    byte_en;
  logic          misalign;
  logic          illegal;

  logic        reg_write_d,  reg_write_q;
  logic        mem_to_reg_d, mem_to_reg_q;
  logic [31:0] read_data_d,  read_data_q;
  logic [31:0] alu_result_d, alu_result_q;
  logic [31:0] pc_add_d,     pc_add_q;
  logic [4:0]  rd_reg_d,     rd_reg_q;
  logic        misalign_d,   misalign_q;

  // Upper address bits are dropped so accesses wrap around the array.
  assign word_idx = bus.ALUResult[AW+1:2];
  assign byte_sel = bus.ALUResult[1:0];
  assign rd_word  = mem[word_idx];

  // Decode the access: byte lanes to write, replicated store data, the
  // sign-extended load value and the misalignment/illegal-combination flag.
  always_comb begin
    byte_en    = 4'b0000;
    store_data = bus.RData2;
    load_data  = 32'h0;
    misalign   = 1'b0;
    rd_byte    = rd_word[8*byte_sel +: 8];
    illegal    = (bus.MemRead != 2'b00) && (bus.MemWrite != 2'b00);

    case (bus.MemWrite)
      2'b01: begin
        if (byte_sel == 2'b00) byte_en = 4'b1111;
        else                   misalign = 1'b1;
      end
      2'b10: begin
        store_data = {2{bus.RData2[15:0]}};
        if (!byte_sel[0]) byte_en = byte_sel[1] ? 4'b1100 : 4'b0011;
        else              misalign = 1'b1;
      end
      2'b11: begin
        store_data = {4{bus.RData2[7:0]}};
        byte_en    = 4'b0001 << byte_sel;
      end
      default: ;
    endcase

    case (bus.MemRead)
      2'b01: begin
        if (byte_sel == 2'b00) load_data = rd_word;
        else                   misalign = 1'b1;
      end
      2'b10: begin
        if (!byte_sel[0])
          load_data = byte_sel[1] ? {{16{rd_word[31]}}, rd_word[31:16]}
                                  : {{16{rd_word[15]}}, rd_word[15:0]};
        else
          misalign = 1'b1;
      end
      2'b11:   load_data = {{24{rd_byte[7]}}, rd_byte};
      default: ;
    endcase

    // A simultaneous load and store keeps the store but zeroes the load.
    if (illegal) begin
      load_data = 32'h0;
      misalign  = 1'b1;
    end
  end

  // Byte-lane writes into the array; suppressed while Reset is asserted and
  // never cleared by it.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[word_idx][8*k +: 8] <= store_data[8*k +: 8];
      end
    end
  end

  // Next-state values of the MEM/WB register.
  always_comb begin
    reg_write_d  = bus.RegWrite;
    mem_to_reg_d = bus.MemToReg;
    read_data_d  = load_data;
    alu_result_d = bus.ALUResult;
    pc_add_d     = bus.PCAddResult;
    rd_reg_d     = bus.RdReg;
    misalign_d   = misalign;
  end

  // MEM/WB pipeline register with synchronous clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      read_data_q  <= 32'h0;
      alu_result_q <= 32'h0;
      pc_add_q     <= 32'h0;
      rd_reg_q     <= 5'h0;
      misalign_q   <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      pc_add_q     <= pc_add_d;
      rd_reg_q     <= rd_reg_d;
      misalign_q   <= misalign_d;
    end
  end

  assign bus.RegWriteOut    = reg_write_q;
  assign bus.MemToRegOut    = mem_to_reg_q;
  assign bus.ReadDataOut    = read_data_q;
  assign bus.ALUResultOut   = alu_result_q;
  assign bus.PCAddResultOut = pc_add_q;
  assign bus.RdRegOut       = rd_reg_q;
  assign bus.MisalignOut    = misalign_q;
  assign bus.WbData         = mem_to_reg_q ? read_data_q : alu_result_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage. Expected results come from a
// byte-addressed 4 KB reference memory kept in the bench.
module tb_data_mem_stage;

  logic clk = 1'b0;
  logic reset;

  data_mem_stage_if bus();

  data_mem_stage #(.DEPTH_WORDS(1024)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory: one entry per byte address, plus a written-yet flag.
  logic [7:0] ref_bytes [4096];
  bit         ref_known [4096];

  logic        exp_reg_write, exp_mem_to_reg, exp_mis;
  logic [31:0] exp_read, exp_alu, exp_pc, exp_wb;
  logic [4:0]  exp_rd;
  bit          exp_read_known;

  // Drive one instruction and predict its MEM/WB result from the byte model.
  task automatic apply_stimulus(input logic rst, input logic rw, input logic m2r,
                                input logic [1:0] wr, input logic [1:0] rd,
                                input logic [31:0] data, input logic [31:0] addr,
                                input logic [31:0] pc, input logic [4:0] rdreg);
    int base;
    logic [7:0] b0, b1, b2, b3;
    bit k0, k1, k2, k3, mis_st, mis_ld, both;
    logic [31:0] ld;
    bit ld_known;
    reset           = rst;
    bus.RegWrite    = rw;
    bus.MemToReg    = m2r;
    bus.MemWrite    = wr;
    bus.MemRead     = rd;
    bus.RData2      = data;
    bus.ALUResult   = addr;
    bus.PCAddResult = pc;
    bus.RdReg       = rdreg;

    base = int'(addr[11:0]);
    b0 = ref_bytes[base];            k0 = ref_known[base];
    b1 = ref_bytes[(base+1) % 4096]; k1 = ref_known[(base+1) % 4096];
    b2 = ref_bytes[(base+2) % 4096]; k2 = ref_known[(base+2) % 4096];
    b3 = ref_bytes[(base+3) % 4096]; k3 = ref_known[(base+3) % 4096];

    mis_st = (wr == 2'b01 && addr[1:0] != 2'b00) || (wr == 2'b10 && addr[0]);
    mis_ld = (rd == 2'b01 && addr[1:0] != 2'b00) || (rd == 2'b10 && addr[0]);
    both   = (rd != 2'b00) && (wr != 2'b00);

    ld = 32'h0;
    ld_known = 1'b1;
    if (!both && !mis_ld) begin
      if (rd == 2'b01) begin
        ld = {b3, b2, b1, b0};
        ld_known = k0 && k1 && k2 && k3;
      end else if (rd == 2'b10) begin
        ld = {{16{b1[7]}}, b1, b0};
        ld_known = k0 && k1;
      end else if (rd == 2'b11) begin
        ld = {{24{b0[7]}}, b0};
        ld_known = k0;
      end
    end

    if (rst) begin
      exp_reg_write = 1'b0; exp_mem_to_reg = 1'b0; exp_mis = 1'b0;
      exp_read = 32'h0; exp_alu = 32'h0; exp_pc = 32'h0; exp_rd = 5'h0;
      exp_read_known = 1'b1;
    end else begin
      exp_reg_write  = rw;
      exp_mem_to_reg = m2r;
      exp_mis        = mis_st || mis_ld || both;
      exp_read       = ld;
      exp_read_known = ld_known;
      exp_alu        = addr;
      exp_pc         = pc;
      exp_rd         = rdreg;
    end
    exp_wb = exp_mem_to_reg ? exp_read : exp_alu;

    // The load above already used the pre-store contents.
    if (!rst && wr != 2'b00 && !mis_st) begin
      for (int k = 0; k < 4; k++) begin
        if (wr == 2'b01 || (wr == 2'b10 && k < 2) || (wr == 2'b11 && k < 1)) begin
          ref_bytes[(base + k) % 4096] = data[8*k +: 8];
          ref_known[(base + k) % 4096] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_stimulus(1'b1, 1'b1, 1'b1, 2'b01, 2'b00, 32'hFFFF_FFFF, 32'h40, 32'h1234, 5'd7);
    step();
    step();
    n_checks++;
    if (bus.RegWriteOut !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_regwrite: got %0b expected 0", bus.RegWriteOut); end
    n_checks++;
    if (bus.WbData !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_wbdata: got %h expected 00000000", bus.WbData); end
    n_checks++;
    if (bus.PCAddResultOut !== 32'h0 || bus.RdRegOut !== 5'h0 || bus.MisalignOut !== 1'b0)
      begin n_fail++; $display("[TB] FAIL reset_outs: got pc=%h rd=%h mis=%0b expected all 0", bus.PCAddResultOut, bus.RdRegOut, bus.MisalignOut); end

    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 32'h0, 32'h40, 32'h0, 5'd0);
    step();
    apply_stimulus(1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 32'hFFFF_FFFF, 32'h40, 32'h88, 5'd3);
    step();
    n_checks++;
    if (bus.RegWriteOut !== 1'b0 || bus.WbData !== 32'h0 || bus.ALUResultOut !== 32'h0)
      begin n_fail++; $display("[TB] FAIL reset_store_outs: got rw=%0b wb=%h alu=%h expected 0", bus.RegWriteOut, bus.WbData, bus.ALUResultOut); end
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 32'h0, 32'h40, 32'h0, 5'd4);
    step();
    n_checks++;
    if (bus.ReadDataOut !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_store_suppressed: got %h expected 00000000", bus.ReadDataOut); end
  endtask

  task automatic test_word();
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 32'hDEAD_BEEF, 32'h10, 32'h100, 5'd0);
    step();
    n_checks++;
    if (bus.MisalignOut !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_misalign: got %0b expected 0", bus.MisalignOut); end
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 32'h0, 32'h10, 32'h104, 5'd9);
    step();
    n_checks++;
    if (bus.ReadDataOut !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL lw_data: got %h expected deadbeef", bus.ReadDataOut); end
    n_checks++;
    if (bus.WbData !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL lw_wbdata: got %h expected deadbeef", bus.WbData); end
  endtask

  task automatic test_subword();
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 32'h0, 32'h20, 32'h0, 5'd0);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 32'hABCD_EF80, 32'h23, 32'h0, 5'd0);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 32'h5678_1234, 32'h20, 32'h0, 5'd0);
    step();
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 32'h0, 32'h20, 32'h0, 5'd1);
    step();
    n_checks++;
    if (bus.ReadDataOut !== 32'h8000_1234) begin n_fail++; $display("[TB] FAIL sub_lw: got %h expected 80001234", bus.ReadDataOut); end
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 32'h0, 32'h23, 32'h0, 5'd2);
    step();
    n_checks++;
    if (bus.ReadDataOut !== 32'hFFFF_FF80) begin n_fail++; $display("[TB] FAIL sub_lb: got %h expected ffffff80", bus.ReadDataOut); end
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 32'h0, 32'h20, 32'h0, 5'd3);
    step();
    n_checks++;
    if (bus.ReadDataOut !== 32'h0000_1234) begin n_fail++; $display("[TB] FAIL sub_lh: got %h expected 00001234", bus.ReadDataOut); end
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 32'h0, 32'h22, 32'h0, 5'd3);
    step();
    n_checks++;
    if (bus.ReadDataOut !== 32'hFFFF_8000) begin n_fail++; $display("[TB] FAIL sub_lh_upper: got %h expected ffff8000", bus.ReadDataOut); end
  endtask

  task automatic test_misalign();
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 32'h1357_9BDF, 32'h12, 32'h0, 5'd0);
    step();
    n_checks++;
    if (bus.MisalignOut !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_sw_flag: got %0b expected 1", bus.MisalignOut); end
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 32'h0, 32'h10, 32'h0, 5'd5);
    step();
    n_checks++;
    if (bus.ReadDataOut !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL mis_sw_unchanged: got %h expected deadbeef", bus.ReadDataOut); end
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 32'h0, 32'h21, 32'h0, 5'd6);
    step();
    n_checks++;
    if (bus.ReadDataOut !== 32'h0 || bus.MisalignOut !== 1'b1)
      begin n_fail++; $display("[TB] FAIL mis_lh: got data=%h mis=%0b expected 00000000 1", bus.ReadDataOut, bus.MisalignOut); end
    // Load and store together: store goes ahead, load reads zero.
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 32'h0BAD_F00D, 32'h10, 32'h0, 5'd6);
    step();
    n_checks++;
    if (bus.ReadDataOut !== 32'h0 || bus.MisalignOut !== 1'b1)
      begin n_fail++; $display("[TB] FAIL illegal_combo: got data=%h mis=%0b expected 00000000 1", bus.ReadDataOut, bus.MisalignOut); end
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 32'h0, 32'h10, 32'h0, 5'd6);
    step();
    n_checks++;
    if (bus.ReadDataOut !== 32'h0BAD_F00D) begin n_fail++; $display("[TB] FAIL illegal_store_done: got %h expected 0badf00d", bus.ReadDataOut); end
  endtask

  task automatic test_back_to_back();
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 32'h2222_2222, 32'h30, 32'h0, 5'd0);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 32'h1111_1111, 32'h30, 32'h0, 5'd0);
    #1;
    n_checks++;
    if (dut.mem[12] !== 32'h2222_2222) begin n_fail++; $display("[TB] FAIL rdw_old_value: got %h expected 22222222", dut.mem[12]); end
    step();
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 32'h0, 32'h30, 32'h0, 5'd8);
    step();
    n_checks++;
    if (bus.ReadDataOut !== 32'h1111_1111) begin n_fail++; $display("[TB] FAIL b2b_lw: got %h expected 11111111", bus.ReadDataOut); end
  endtask

  task automatic test_wrap_passthrough();
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 32'hA5A5_A5A5, 32'h1004, 32'h0, 5'd0);
    step();
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 32'h0, 32'h4, 32'h0040_0AB8, 5'd31);
    step();
    n_checks++;
    if (bus.ReadDataOut !== 32'hA5A5_A5A5) begin n_fail++; $display("[TB] FAIL wrap_lw: got %h expected a5a5a5a5", bus.ReadDataOut); end
    n_checks++;
    if (bus.PCAddResultOut !== 32'h0040_0AB8 || bus.RdRegOut !== 5'd31 || bus.RegWriteOut !== 1'b1)
      begin n_fail++; $display("[TB] FAIL passthrough: got pc=%h rd=%0d rw=%0b expected 00400ab8 31 1", bus.PCAddResultOut, bus.RdRegOut, bus.RegWriteOut); end
    // Non-memory instruction: write-back takes the ALU result.
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h0, 32'hCAFE_0001, 32'h4, 5'd2);
    step();
    n_checks++;
    if (bus.WbData !== 32'hCAFE_0001 || bus.ReadDataOut !== 32'h0)
      begin n_fail++; $display("[TB] FAIL alu_wb: got wb=%h rd=%h expected cafe0001 00000000", bus.WbData, bus.ReadDataOut); end
  endtask

  task automatic test_random();
    logic [31:0] addr, data;
    logic [1:0] wr, rd;
    int sel;
    for (int w = 0; w < 16; w++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, $urandom(), 32'(w * 4), 32'h0, 5'd0);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      addr = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      data = $urandom();
      sel  = $urandom_range(0, 9);
      wr = 2'b00;
      rd = 2'b00;
      if (sel < 4)       rd = 2'($urandom_range(1, 3));
      else if (sel < 8)  wr = 2'($urandom_range(1, 3));
      else if (sel == 8) begin rd = 2'($urandom_range(1, 3)); wr = 2'($urandom_range(1, 3)); end
      apply_stimulus(($urandom_range(0, 24) == 0), 1'($urandom()), 1'($urandom()), wr, rd,
                     data, addr, $urandom(), 5'($urandom()));
      step();
      n_checks++;
      if (exp_read_known && bus.ReadDataOut !== exp_read)
        begin n_fail++; $display("[TB] FAIL rand_read[%0d]: got %h expected %h", i, bus.ReadDataOut, exp_read); end
      n_checks++;
      if (bus.MisalignOut !== exp_mis)
        begin n_fail++; $display("[TB] FAIL rand_mis[%0d]: got %0b expected %0b", i, bus.MisalignOut, exp_mis); end
      n_checks++;
      if (bus.RegWriteOut !== exp_reg_write || bus.MemToRegOut !== exp_mem_to_reg || bus.RdRegOut !== exp_rd)
        begin n_fail++; $display("[TB] FAIL rand_ctrl[%0d]: got rw=%0b m2r=%0b rd=%0d expected %0b %0b %0d", i, bus.RegWriteOut, bus.MemToRegOut, bus.RdRegOut, exp_reg_write, exp_mem_to_reg, exp_rd); end
      n_checks++;
      if (bus.ALUResultOut !== exp_alu || bus.PCAddResultOut !== exp_pc)
        begin n_fail++; $display("[TB] FAIL rand_pass[%0d]: got alu=%h pc=%h expected %h %h", i, bus.ALUResultOut, bus.PCAddResultOut, exp_alu, exp_pc); end
      n_checks++;
      if ((exp_read_known || !exp_mem_to_reg) && bus.WbData !== exp_wb)
        begin n_fail++; $display("[TB] FAIL rand_wb[%0d]: got %h expected %h", i, bus.WbData, exp_wb); end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_misalign();
    test_back_to_back();
    test_wrap_passthrough();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
